// File: rtl/irq_ctrl_if.sv
// System data bus port shared by the memory-mapped peripherals:
// register select, qualified write strobe, write data and registered read data.
interface irq_ctrl_if;
  logic [1:0] addr;
  logic       we;
  logic [7:0] dbw;
  logic [7:0] dbr;

  modport master (output addr, output we, output dbw, input dbr);
  modport slave  (input addr, input we, input dbw, output dbr);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source level/edge pending capture, enable mask,
// W1C/W1S pending control, fixed-priority vector and a registered CPU IRQ.
module irq_ctrl #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            rst,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  // Registers are kept 8 bits wide; bits at NSRC and above are held at zero.
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NSRC) - 9'd1);

  logic [7:0] src_ext;
  logic [7:0] wdata;
  logic [7:0] clr;
  logic [7:0] set;
  logic [7:0] rise;
  logic [7:0] pend_en;
  logic [2:0] idx;

  logic [7:0] src_q, src_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] dbr_q, dbr_d;
  logic       irq_q, irq_d;

  always_comb begin
    src_ext = '0;
    src_ext[NSRC-1:0] = src;
    wdata = bus.dbw & SRC_MASK;
    clr   = (bus.we && bus.addr == 2'd0) ? wdata : 8'h00;
    set   = (bus.we && bus.addr == 2'd3) ? wdata : 8'h00;
    rise  = src_ext & ~src_q;
    src_d = src_ext;

    // Level bits follow src directly; edge bits latch, and set/rise beat clear.
    pending_d = (src_ext & ~mode_q) | (mode_q & ((pending_q & ~clr) | rise | set));

    enable_d = (bus.we && bus.addr == 2'd1) ? wdata : enable_q;
    mode_d   = (bus.we && bus.addr == 2'd2) ? wdata : mode_q;

    pend_en = pending_q & enable_q;
    irq_d   = |pend_en;

    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_en[i]) idx = i[2:0];
    end

    case (bus.addr)
      2'd0:    dbr_d = pending_q;
      2'd1:    dbr_d = enable_q;
      2'd2:    dbr_d = mode_q;
      default: dbr_d = {irq_q, 4'b0000, idx};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= 8'h00;
      pending_q <= 8'h00;
      enable_q  <= 8'h00;
      mode_q    <= 8'h00;
      dbr_q     <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      src_q     <= src_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      dbr_q     <= dbr_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.dbr = dbr_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus a randomized run compared
// cycle by cycle with a behavioural register-level model.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] src;
  logic       irq;

  int checks;
  int errors;

  irq_ctrl_if bus ();

  irq_ctrl #(.NSRC(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .src(src),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] m_pend;
  logic [3:0] m_en;
  logic [3:0] m_mode;
  logic [3:0] m_srcq;
  logic [7:0] m_dbr;
  logic       m_irq;

  // Lowest set bit index by arithmetic: isolate it, then count the bits below it.
  function automatic logic [2:0] vec_index(input logic [3:0] pe);
    int v;
    v = int'(pe);
    if (v == 0) return 3'd0;
    return 3'($countones((v & -v) - 1));
  endfunction

  task automatic model_update(input logic [1:0] a, input logic w, input logic [7:0] d,
                              input logic [3:0] s);
    logic [3:0] pe;
    logic [3:0] nxt;
    pe = m_pend & m_en;
    case (a)
      2'd0: m_dbr = {4'h0, m_pend};
      2'd1: m_dbr = {4'h0, m_en};
      2'd2: m_dbr = {4'h0, m_mode};
      default: m_dbr = {m_irq, 4'h0, vec_index(pe)};
    endcase
    m_irq = (pe != 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (m_mode[i]) begin
        nxt[i] = m_pend[i];
        if (w && a == 2'd0 && d[i]) nxt[i] = 1'b0;
        if (s[i] && !m_srcq[i]) nxt[i] = 1'b1;
        if (w && a == 2'd3 && d[i]) nxt[i] = 1'b1;
      end else begin
        nxt[i] = s[i];
      end
    end
    if (w && a == 2'd1) m_en = d[3:0];
    if (w && a == 2'd2) m_mode = d[3:0];
    m_pend = nxt;
    m_srcq = s;
  endtask

  task automatic cycle(input logic [1:0] a, input logic w, input logic [7:0] d,
                       input logic [3:0] s);
    bus.addr = a;
    bus.we   = w;
    bus.dbw  = d;
    src      = s;
    @(posedge clk);
    model_update(a, w, d, s);
    #1;
  endtask

  task automatic model_clear();
    m_pend = 4'h0;
    m_en   = 4'h0;
    m_mode = 4'h0;
    m_srcq = 4'h0;
    m_dbr  = 8'h00;
    m_irq  = 1'b0;
  endtask

  task automatic do_reset();
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.dbw  = 8'h00;
    src      = 4'h0;
    rst      = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(2'd2, 1'b1, 8'h0F, 4'h0);
    cycle(2'd1, 1'b1, 8'h0F, 4'h0);
    cycle(2'd3, 1'b1, 8'h0F, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h0F || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_preload: dbr=%h irq=%b expected dbr=0f irq=1", bus.dbr, irq);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (irq !== 1'b0 || bus.dbr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async: dbr=%h irq=%b expected dbr=00 irq=0", bus.dbr, irq);
    end
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cycle(2'(a), 1'b0, 8'h00, 4'h0);
      checks++;
      if (bus.dbr !== 8'h00 || irq !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_read%0d: dbr=%h irq=%b expected dbr=00 irq=0", a, bus.dbr, irq);
      end
    end
  endtask

  task automatic test_level();
    do_reset();
    cycle(2'd1, 1'b1, 8'h01, 4'h0);
    cycle(2'd2, 1'b1, 8'h00, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h1);
    cycle(2'd0, 1'b0, 8'h00, 4'h1);
    checks++;
    if (bus.dbr !== 8'h01 || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL level_assert: dbr=%h irq=%b expected dbr=01 irq=1", bus.dbr, irq);
    end
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_drop: dbr=%h irq=%b expected dbr=00 irq=0", bus.dbr, irq);
    end
  endtask

  task automatic test_edge_w1c();
    do_reset();
    cycle(2'd2, 1'b1, 8'h02, 4'h0);
    cycle(2'd1, 1'b1, 8'h02, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h2);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h02 || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_latch: dbr=%h irq=%b expected dbr=02 irq=1", bus.dbr, irq);
    end
    cycle(2'd0, 1'b1, 8'h02, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_w1c: dbr=%h irq=%b expected dbr=00 irq=0", bus.dbr, irq);
    end
  endtask

  task automatic test_collision();
    do_reset();
    cycle(2'd2, 1'b1, 8'h02, 4'h0);
    cycle(2'd3, 1'b1, 8'h02, 4'h0);
    cycle(2'd0, 1'b1, 8'h02, 4'h2);
    cycle(2'd0, 1'b0, 8'h00, 4'h2);
    checks++;
    if (bus.dbr !== 8'h02) begin
      errors++;
      $display("[TB] FAIL collision_keep: dbr=%h expected 02", bus.dbr);
    end
    cycle(2'd0, 1'b1, 8'h02, 4'h2);
    cycle(2'd0, 1'b0, 8'h00, 4'h2);
    checks++;
    if (bus.dbr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL collision_held_high_clear: dbr=%h expected 00", bus.dbr);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cycle(2'd2, 1'b1, 8'h0F, 4'h0);
    cycle(2'd1, 1'b1, 8'h0C, 4'h0);
    cycle(2'd3, 1'b1, 8'h0E, 4'h0);
    cycle(2'd3, 1'b0, 8'h00, 4'h0);
    cycle(2'd3, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h82) begin
      errors++;
      $display("[TB] FAIL vector_first: dbr=%h expected 82", bus.dbr);
    end
    cycle(2'd0, 1'b1, 8'h04, 4'h0);
    cycle(2'd3, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h83) begin
      errors++;
      $display("[TB] FAIL vector_after_clear: dbr=%h expected 83", bus.dbr);
    end
  endtask

  task automatic test_mask_rdw();
    do_reset();
    cycle(2'd2, 1'b1, 8'h01, 4'h0);
    cycle(2'd3, 1'b1, 8'h01, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    cycle(2'd0, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h01 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mask_off: dbr=%h irq=%b expected dbr=01 irq=0", bus.dbr, irq);
    end
    cycle(2'd1, 1'b1, 8'hFF, 4'h0);
    checks++;
    if (bus.dbr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rdw_old: dbr=%h expected 00", bus.dbr);
    end
    cycle(2'd1, 1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.dbr !== 8'h0F || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rdw_new: dbr=%h irq=%b expected dbr=0f irq=1", bus.dbr, irq);
    end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic       w;
    logic [7:0] d;
    logic [3:0] s;
    do_reset();
    s = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      s = s ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      cycle(a, w, d, s);
      checks++;
      if (bus.dbr !== m_dbr || irq !== m_irq) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: dbr=%h irq=%b expected dbr=%h irq=%b",
                 n, bus.dbr, irq, m_dbr, m_irq);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    src      = 4'h0;
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.dbw  = 8'h00;
    model_clear();
    test_reset();
    test_level();
    test_edge_w1c();
    test_collision();
    test_priority();
    test_mask_rdw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller that collects interrupt requests from the on-chip peripherals (timer, UART, future blocks) and drives the CPU IRQ input, which is currently tied low. It sits on the system data bus at $FE40-$FE5F, decoded like the other peripherals. It has the same bus port set and registered-read timing as the timer and UART. Per-source enable, level/edge mode, W1C clear, software trigger and a priority vector register.

Parameters:
NSRC, 4, number of interrupt sources; legal range 1..8; register bits at NSRC and above read 0 and ignore writes.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
addr  input  2  register select (system addr[1:0])
we  input  1  write strobe, already qualified with chip select by the system
dbw  input  8  write data from CPU
dbr  output  8  read data, registered
src  input  NSRC  interrupt request lines from peripherals, synchronous to clk, active-high
irq  output  1  interrupt request to CPU, active-high level, registered

Behaviour:
- Register map:
  - 0 STATUS: read returns pending[NSRC-1:0]. Write is W1C; it clears edge-mode pending bits where dbw=1.
  - 1 ENABLE: R/W.
  - 2 MODE: R/W; 1=rising-edge, 0=level.
  - 3 VECTOR: read returns bit7=irq (current registered value), bits2:0=index of lowest-numbered bit of pending&enable (0 if none), bits6:3=0. Write is W1S; it sets edge-mode pending bits where dbw=1.
- Reset (async, rst high): pending, enable, mode, src_q, dbr, irq all 0. Deassertion takes effect at the next posedge.
- src_q <= src every cycle regardless of mode. rise = src & ~src_q.
- Level-mode bit i: pending[i] <= src[i] each posedge. W1C and W1S are ignored for that bit.
- Edge-mode bit i: pending[i] <= (pending[i] & ~clr[i]) | rise[i] | set[i].
  - Simultaneous W1C and rise on the same bit in the same cycle: set wins, and pending stays 1.
  - Pending stays set until cleared by W1C, even if src drops.
- Latency:
  - src sampled high at posedge k (low at k-1) sets pending at posedge k.
  - irq <= |(pending & enable) at posedge k+1.
  - The same applies to level mode: irq asserts one cycle after pending.
  - Clearing enable or pending drops irq one posedge after the register update.
- Bus timing:
  - Writes take effect at the posedge where we=1.
  - dbr <= selected register value at every posedge, regardless of we, using pre-update register values. Read of the same cycle as a write returns the old value.
  - The system's registered chip select expects dbr valid in the cycle after addr.
- Mode change: writing MODE does not alter the current pending value. The next update follows the new mode. Because src_q always tracks src, switching level->edge while src is high produces no spurious edge.
- After reset src_q=0, so a src line already high when a bit is switched to edge mode does not trigger (src_q has caught up). A src line high on the first cycle after reset counts as a rise only if that bit's mode is edge; mode resets to level.
- Priority: VECTOR index is fixed, source 0 highest. It is combinational from pending&enable and then registered into dbr.
- Write data bits >= NSRC are ignored. Read bits >= NSRC are 0 (except VECTOR bit7).

Test Plan:
- Reset: assert rst mid-operation with pending=4'hF, enable=4'hF -> irq=0, dbr=0 and all registers read 0 immediately after release.
- Level: ENABLE=4'h1, MODE=0, raise src[0] at posedge k -> STATUS reads 8'h01 and irq=1 at posedge k+1. Drop src[0] -> pending=0, irq=0 one cycle later.
- Edge latch and W1C: MODE=4'h2, ENABLE=4'h2, pulse src[1] for 1 cycle -> STATUS=8'h02 and irq stays 1. Write STATUS 8'h02 -> STATUS=0 and irq=0 two posedges later.
- Clear/edge collision: MODE=4'h2, a W1C of bit1 in the same cycle as a new src[1] rise -> pending[1] remains 1.
- Priority vector: MODE=4'hF, ENABLE=4'hC, W1S 8'h0E -> VECTOR reads 8'h82. After W1C 8'h04 -> VECTOR reads 8'h83.
- Masking and read-during-write: pending=4'h1 with ENABLE=0 -> irq=0. Write ENABLE=8'hFF and read ENABLE in the same cycle -> dbr=8'h00 that cycle, 8'h0F next, irq=1.
